// File: rtl/iterative_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/busy handshake on issue and a one-cycle done pulse with held results.
module iterative_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned EXT_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DBZ  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [EXT_W-1:0]   shifted;
    logic [EXT_W-1:0]   trial;

    // Partial remainder stays below the divisor, so its stored copy needs only
    // WIDTH bits; the extra bit lives only in the trial subtraction.
    always_comb begin
        shifted = {1'b0, r_q, q_q[WIDTH-1]};
        trial   = shifted + (~{1'b0, d_q}) + EXT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    d_d     = divisor_i;
                    q_d     = dividend_i;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = (divisor_i == '0) ? DBZ : RUN;
                end
            end
            RUN: begin
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shifted[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                end
            end
            DBZ: begin
                state_d = DONE;
                quo_d   = '1;
                rem_d   = q_q;
                dbz_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DBZ);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: expected results queued at issue,
// compared on each done pulse, plus latency, hold and reset checks.
module tb_iterative_divider;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_by_zero_o;

    int           n_cmp = 0;
    int           n_err = 0;
    exp_t         sb[$];
    logic [W-1:0] last_q;

    iterative_divider #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Result checker: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("busy_done_excl", 32'(busy_o & done_o), 32'd0);
            if (done_o) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("quotient", 32'(quotient_o), 32'(e.q));
                    check_eq("remainder", 32'(remainder_o), 32'(e.r));
                    check_eq("div_by_zero", 32'(div_by_zero_o), 32'(e.dbz));
                end
            end
        end
    end

    // Issue one op; with now=1 start is driven in the current (DONE) cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit now,
                         input int exp_lat);
        int   lat;
        exp_t e;
        if (!now) @(negedge clk);
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        e = model(a, b);
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        check_eq("busy_after_accept", 32'(busy_o), 32'd1);
        check_eq("hold_quotient", 32'(quotient_o), 32'(last_q));
        while (!done_o && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        last_q = e.q;
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        last_q     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_quotient", 32'(quotient_o), 32'd0);
        check_eq("rst_remainder", 32'(remainder_o), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero_o), 32'd0);

        do_op(16'd100, 16'd7, 1'b0, 17);
        do_op(16'hFFFF, 16'd1, 1'b0, 17);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 17);
        do_op(16'd3, 16'd10, 1'b0, 17);
        do_op(16'd0, 16'd5, 1'b0, 17);
        do_op(16'd5, 16'd0, 1'b0, 2);

        // Start held through RUN with junk operands: only the first op counts.
        @(negedge clk);
        dividend_i = 16'd100;
        divisor_i  = 16'd7;
        start_i    = 1'b1;
        sb.push_back(model(16'd100, 16'd7));
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            dividend_i = W'($urandom);
            divisor_i  = W'($urandom_range(0, 3));
        end
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check_eq("held_start_done", 32'(done_o), 32'd1);
        last_q = 16'd14;
        @(negedge clk);
        check_eq("held_start_idle", 32'(busy_o), 32'd0);
        check_eq("held_start_sb", 32'(sb.size()), 32'd0);

        // Back-to-back: second start issued in the DONE cycle.
        do_op(16'd1000, 16'd33, 1'b0, 17);
        do_op(16'd1234, 16'd0, 1'b1, 2);
        do_op(16'd60000, 16'd255, 1'b1, 17);

        // Reset in the middle of an op discards it.
        @(negedge clk);
        dividend_i = 16'd100;
        divisor_i  = 16'd7;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy_o), 32'd0);
        check_eq("midrst_done", 32'(done_o), 32'd0);
        check_eq("midrst_quotient", 32'(quotient_o), 32'd0);
        check_eq("midrst_remainder", 32'(remainder_o), 32'd0);
        check_eq("midrst_dbz", 32'(div_by_zero_o), 32'd0);
        last_q = '0;
        do_op(16'd50, 16'd7, 1'b0, 17);

        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            int unsigned  sel;
            a   = W'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = '0;
            else if (sel <= 2) b = W'($urandom_range(1, 15));
            else               b = W'($urandom);
            do_op(a, b, 1'($urandom_range(0, 1)), (b == '0) ? 2 : 17);
        end

        @(negedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
